// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: iterative double-dabble binary to packed-BCD converter.
// A conversion takes IN_W shift cycles plus one finish cycle. The results
// (bcd, blank, overflow) are registered and only change on the done edge,
// so a downstream display never sees a partially converted value.
//
// Handshake: start is sampled only while IDLE; the edge that samples it
// captures bin and raises busy. Any start seen while busy (or on the done
// edge) is dropped. done is a single-cycle pulse on the cycle the new
// result becomes visible; busy falls on that same edge.
module bin_to_bcd_seq #(
    parameter int IN_W   = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [IN_W-1:0]       bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     blank,
    output logic                  overflow
);

    // Accumulator carries one extra guard digit above the displayed digits.
    localparam int ACC_W = 4*DIGITS + 4;
    localparam int CNT_W = $clog2(IN_W + 1);
    localparam int SH_W  = ACC_W + IN_W;

    // Largest value that fits in DIGITS decimal digits.
    localparam logic [IN_W-1:0]   MAX_VAL   = IN_W'(10**DIGITS - 1);
    // Every digit blanked except the units digit, which always shows.
    localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [IN_W-1:0]    sr;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   acc_adj;
    logic [SH_W-1:0]    shifted;
    logic [CNT_W-1:0]   cnt;
    logic               big_q;

    logic [4*DIGITS-1:0] bcd_fin;
    logic [DIGITS-1:0]   blank_fin;
    logic                ovf_fin;
    logic                zero_run;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: IDLE -> SHIFT on start, IN_W shifts, one FINISH cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (cnt == CNT_W'(1)) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Add-3 correction on every accumulator nibble >= 5, then the left shift.
    always_comb begin
        acc_adj = acc;
        for (int d = 0; d < DIGITS + 1; d++) begin
            if (acc[4*d +: 4] >= 4'd5) begin
                acc_adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
            end
        end
        shifted = {acc_adj, sr} << 1;
    end

    // Final result: saturate to all nines on overflow, then derive the
    // leading-zero mask from the value that will actually be shown.
    always_comb begin
        ovf_fin   = big_q || (acc[ACC_W-1 -: 4] != 4'h0);
        bcd_fin   = ovf_fin ? {DIGITS{4'h9}} : acc[4*DIGITS-1:0];
        blank_fin = '0;
        zero_run  = 1'b1;
        for (int d = DIGITS - 1; d >= 1; d--) begin
            zero_run     = zero_run && (bcd_fin[4*d +: 4] == 4'h0);
            blank_fin[d] = zero_run;
        end
    end

    // Datapath, handshake flags and held result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr       <= '0;
            acc      <= '0;
            cnt      <= '0;
            big_q    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd      <= '0;
            blank    <= BLANK_RST;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sr    <= bin;
                        acc   <= '0;
                        cnt   <= CNT_W'(IN_W);
                        big_q <= (bin > MAX_VAL);
                        busy  <= 1'b1;
                    end
                end
                SHIFT: begin
                    acc <= shifted[SH_W-1:IN_W];
                    sr  <= shifted[IN_W-1:0];
                    cnt <= cnt - CNT_W'(1);
                end
                FINISH: begin
                    bcd      <= bcd_fin;
                    blank    <= blank_fin;
                    overflow <= ovf_fin;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq with default parameters (14-bit input,
// four BCD digits). Inputs change and outputs are sampled 1 ns after the
// rising clock edge.
module tb_bin_to_bcd_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [13:0] bin;
    logic        busy;
    logic        done;
    logic [15:0] bcd;
    logic [3:0]  blank;
    logic        overflow;

    int n_vec;
    int n_err;

    bin_to_bcd_seq #(.IN_W(14), .DIGITS(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .bin      (bin),
        .busy     (busy),
        .done     (done),
        .bcd      (bcd),
        .blank    (blank),
        .overflow (overflow)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Driver: one-cycle start pulse, then wait (bounded) for done.
    // lat = edges from the accepting edge to the done edge.
    task automatic do_convert(input logic [13:0] v, output int lat, output int busy_cnt);
        start = 1'b1;
        bin   = v;
        step();
        start    = 1'b0;
        lat      = 0;
        busy_cnt = 0;
        while (!done && lat < 100) begin
            if (busy) busy_cnt++;
            step();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        bin   = '0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (busy !== 1'b0)      begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_vec++; if (done !== 1'b0)      begin n_err++; $display("FAIL reset_done got %b want 0", done); end
        n_vec++; if (bcd !== 16'h0000)   begin n_err++; $display("FAIL reset_bcd got %h want 0000", bcd); end
        n_vec++; if (blank !== 4'b1110)  begin n_err++; $display("FAIL reset_blank got %b want 1110", blank); end
        n_vec++; if (overflow !== 1'b0)  begin n_err++; $display("FAIL reset_overflow got %b want 0", overflow); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        int lat, bc;
        do_convert(14'd1234, lat, bc);
        n_vec++; if (lat !== 15)        begin n_err++; $display("FAIL basic_latency got %0d want 15", lat); end
        n_vec++; if (bc !== 15)         begin n_err++; $display("FAIL basic_busy_cycles got %0d want 15", bc); end
        n_vec++; if (busy !== 1'b0)     begin n_err++; $display("FAIL basic_busy_at_done got %b want 0", busy); end
        n_vec++; if (bcd !== 16'h1234)  begin n_err++; $display("FAIL basic_bcd got %h want 1234", bcd); end
        n_vec++; if (blank !== 4'b0000) begin n_err++; $display("FAIL basic_blank got %b want 0000", blank); end
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL basic_overflow got %b want 0", overflow); end
        step();
        n_vec++; if (done !== 1'b0)     begin n_err++; $display("FAIL basic_done_width got %b want 0", done); end
    endtask

    task automatic test_blanking();
        logic [13:0] vin [3];
        logic [15:0] vbcd [3];
        logic [3:0]  vblk [3];
        int lat, bc;
        vin[0] = 14'd0;   vbcd[0] = 16'h0000; vblk[0] = 4'b1110;
        vin[1] = 14'd7;   vbcd[1] = 16'h0007; vblk[1] = 4'b1110;
        vin[2] = 14'd305; vbcd[2] = 16'h0305; vblk[2] = 4'b1000;
        for (int i = 0; i < 3; i++) begin
            do_convert(vin[i], lat, bc);
            n_vec++; if (lat !== 15)       begin n_err++; $display("FAIL blank_latency[%0d] got %0d want 15", i, lat); end
            n_vec++; if (bcd !== vbcd[i])  begin n_err++; $display("FAIL blank_bcd[%0d] got %h want %h", i, bcd, vbcd[i]); end
            n_vec++; if (blank !== vblk[i]) begin n_err++; $display("FAIL blank_mask[%0d] got %b want %b", i, blank, vblk[i]); end
            n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL blank_overflow[%0d] got %b want 0", i, overflow); end
        end
    endtask

    task automatic test_overflow();
        logic [13:0] vin [3];
        logic        vovf [3];
        int lat, bc;
        vin[0] = 14'd9999;  vovf[0] = 1'b0;
        vin[1] = 14'd10000; vovf[1] = 1'b1;
        vin[2] = 14'd16383; vovf[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            do_convert(vin[i], lat, bc);
            n_vec++; if (lat !== 15)           begin n_err++; $display("FAIL ovf_latency[%0d] got %0d want 15", i, lat); end
            n_vec++; if (bcd !== 16'h9999)     begin n_err++; $display("FAIL ovf_bcd[%0d] got %h want 9999", i, bcd); end
            n_vec++; if (blank !== 4'b0000)    begin n_err++; $display("FAIL ovf_blank[%0d] got %b want 0000", i, blank); end
            n_vec++; if (overflow !== vovf[i]) begin n_err++; $display("FAIL ovf_flag[%0d] got %b want %b", i, overflow, vovf[i]); end
        end
    endtask

    task automatic test_busy_ignore();
        int n_done;
        start = 1'b1;
        bin   = 14'd42;
        step();
        start  = 1'b0;
        n_done = 0;
        // Accepting edge was busy cycle 1; pulse start so it is sampled on cycle 5.
        for (int i = 0; i < 3; i++) begin
            step();
            if (done) n_done++;
        end
        start = 1'b1;
        bin   = 14'd777;
        step();
        if (done) n_done++;
        start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (done) n_done++;
        end
        n_vec++; if (n_done !== 1)      begin n_err++; $display("FAIL ignore_done_count got %0d want 1", n_done); end
        n_vec++; if (bcd !== 16'h0042)  begin n_err++; $display("FAIL ignore_bcd got %h want 0042", bcd); end
        n_vec++; if (busy !== 1'b0)     begin n_err++; $display("FAIL ignore_busy_idle got %b want 0", busy); end
        bin = 14'd1111;
        repeat (10) step();
        n_vec++; if (bcd !== 16'h0042)  begin n_err++; $display("FAIL ignore_bcd_hold got %h want 0042", bcd); end
    endtask

    task automatic test_back_to_back();
        int gap;
        logic [15:0] exp_bcd;
        start = 1'b1;
        bin   = 14'd1;
        step();
        for (int n = 0; n < 3; n++) begin
            gap = 0;
            do begin
                step();
                gap++;
            end while (!done && gap < 100);
            exp_bcd = 16'(n + 1);
            n_vec++; if (gap !== (n == 0 ? 15 : 16)) begin n_err++; $display("FAIL b2b_gap[%0d] got %0d want %0d", n, gap, (n == 0 ? 15 : 16)); end
            n_vec++; if (bcd !== exp_bcd)            begin n_err++; $display("FAIL b2b_bcd[%0d] got %h want %h", n, bcd, exp_bcd); end
            bin = 14'(n + 2);
        end
        start = 1'b0;
        step();
        n_vec++; if (done !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL b2b_stop got done=%b busy=%b want 0 0", done, busy); end
    endtask

    task automatic test_reset_abort();
        int lat, bc, n_done;
        do_convert(14'd1234, lat, bc);
        n_vec++; if (bcd !== 16'h1234)  begin n_err++; $display("FAIL abort_pre_bcd got %h want 1234", bcd); end
        start = 1'b1;
        bin   = 14'd5678;
        step();
        start = 1'b0;
        repeat (6) step();
        rst_n = 1'b0;
        #1;
        n_vec++; if (busy !== 1'b0)      begin n_err++; $display("FAIL abort_busy got %b want 0", busy); end
        n_vec++; if (bcd !== 16'h0000)   begin n_err++; $display("FAIL abort_bcd got %h want 0000", bcd); end
        n_vec++; if (blank !== 4'b1110)  begin n_err++; $display("FAIL abort_blank got %b want 1110", blank); end
        n_vec++; if (overflow !== 1'b0)  begin n_err++; $display("FAIL abort_overflow got %b want 0", overflow); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        n_done = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (done) n_done++;
        end
        n_vec++; if (n_done !== 0)       begin n_err++; $display("FAIL abort_no_done got %0d want 0", n_done); end
        do_convert(14'd5678, lat, bc);
        n_vec++; if (lat !== 15)         begin n_err++; $display("FAIL abort_post_latency got %0d want 15", lat); end
        n_vec++; if (bcd !== 16'h5678)   begin n_err++; $display("FAIL abort_post_bcd got %h want 5678", bcd); end
        n_vec++; if (blank !== 4'b0000)  begin n_err++; $display("FAIL abort_post_blank got %b want 0000", blank); end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_basic();
        test_blanking();
        test_overflow();
        test_busy_ignore();
        test_back_to_back();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
- Iterative shift-add-3 (double-dabble) converter that turns an unsigned binary value into DIGITS packed BCD digits, plus a leading-zero blank mask.
- Sits directly upstream of the 4-digit multiplexed 7-segment display driver and feeds its per-digit data input.
- Lets the display show decimal values (counters, sensor readings) instead of raw hex.
- One conversion takes IN_W+1 cycles. A start/busy/done handshake lets a producer update the value at any rate.

Parameters:
- IN_W, 14, width of the binary input; must satisfy 2^IN_W > 10^DIGITS - 1.
- DIGITS, 4, number of BCD output digits; the default matches the 4-digit display.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a conversion of bin; sampled only in IDLE.
- bin  in  IN_W  unsigned binary value; captured on the accepted start edge.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse when bcd/blank/overflow are updated.
- bcd  out  4*DIGITS  packed BCD; bits [3:0] are the units digit, the top nibble is the most significant digit.
- blank  out  DIGITS  bit i=1 means digit i is a leading zero; bit 0 is always 0.
- overflow  out  1  last accepted bin exceeded 10^DIGITS - 1.

Behaviour:
- Reset (async assert, sync release):
  - busy=0, done=0, bcd=0, overflow=0.
  - blank = all ones except bit 0.
  - Internal shift register and counters cleared; FSM goes to IDLE.
- FSM states: IDLE, SHIFT, FINISH.
- IDLE:
  - On an edge with start=1:
    - capture bin into the shift register;
    - clear the internal BCD accumulator (4*DIGITS+4 bits; one guard digit for overflow detection);
    - load the bit counter with IN_W;
    - set busy=1; go to SHIFT.
  - start=0: stay in IDLE.
- SHIFT, once per cycle:
  - every accumulator nibble >= 5 gets +3 (combinational, before the shift);
  - {accumulator, shift register} shifts left by 1;
  - counter decrements.
  - Leave after exactly IN_W shift cycles and go to FINISH.
- FINISH, one cycle, then IDLE:
  - If the guard digit is nonzero, or any value exceeds 10^DIGITS - 1: bcd = all nibbles 4'h9, overflow=1.
  - Otherwise: bcd = the low 4*DIGITS accumulator bits, overflow=0.
  - blank bit i (i>=1) = 1 iff digit i and every more-significant digit are zero. Computed from the final bcd value.
  - done=1 for this cycle only; busy=0 registered on the same edge.
- Latency: start sampled at edge k → done high during the cycle following edge k+IN_W+1. With defaults, done appears 15 cycles after start is sampled. busy is high for IN_W+1 cycles.
- Output hold: bcd, blank and overflow change only on the done edge. They hold their last values indefinitely, so the display never shows partial results.
- start while busy: ignored; no queuing; the in-flight bin is not disturbed.
- start on the done edge: the FSM is in FINISH, not IDLE, so start is ignored. A producer holding start high is accepted on the following edge, giving back-to-back conversions every IN_W+2 cycles.
- bin changes during a conversion: no effect; only the value captured on acceptance is used.
- Reset mid-conversion: immediate abort. Outputs return to their reset values and no done pulse follows.
- Values of 0 and of exactly 10^DIGITS - 1 are legal; 10^DIGITS and above set overflow.

Test Plan:
- Reset, then start=1 for one cycle with bin=1234 → busy high 15 cycles; done pulse at cycle 15; bcd=16'h1234, blank=4'b0000, overflow=0.
- bin=0 → bcd=16'h0000, blank=4'b1110. Then bin=7 → bcd=16'h0007, blank=4'b1110. Then bin=305 → bcd=16'h0305, blank=4'b1000.
- bin=9999 → bcd=16'h9999, overflow=0. Then bin=10000 → bcd=16'h9999, overflow=1. Then bin=16383 → same saturated result, overflow=1.
- Start bin=42; pulse start with bin=777 on cycle 5 of busy → that start is ignored; exactly one done pulse; bcd=16'h0042. bcd stays at 16'h0042 until the next accepted start completes.
- Hold start=1 continuously, with bin stepping 1,2,3 on each accepted start → done every 16 cycles; bcd sequence 0001, 0002, 0003; done never lasts more than one cycle.
- Complete bin=1234, then start bin=5678 and assert rst_n=0 at cycle 7 → immediately busy=0, bcd=0, blank=4'b1110, overflow=0. No done follows. After release, bin=5678 converts to 16'h5678.
